mmio_region_bus: RTL and testbench
==================================

// Module: mmio_region_bus
// PURPOSE
//  Parametrised memory-map bus controller: the successor to the fixed-address CPU decoder.
//  Decodes CPU accesses into NUM_REGIONS device regions through a base/size table.
//  Each region has its own read latency and write-protect bit, and a req/ready/err handshake
//  replaces the fixed one-cycle combinational read. Unmapped or protected accesses are
//  trapped and recorded in an internal status register.
// PARAMETERS
//  NUM_REGIONS  8         number of device regions (1..16)
//  ADDR_W       16        address width
//  DATA_W       16        data width
//  REGION_BASE  {...}     NUM_REGIONS*ADDR_W packed bases, region i at [i*ADDR_W +: ADDR_W]
//  REGION_MASK  {...}     packed size masks; hit when (addr & ~MASK_i) == BASE_i; sizes are powers of 2
//  REGION_LAT   {...}     NUM_REGIONS*2 packed read latency per region, 1..3 cycles (0 treated as 1)
//  REGION_WP    0         NUM_REGIONS-bit write-protect mask, bit i=1 -> region i read-only
//  STATUS_ADDR  16'h48FF  internal status/error register address (checked before the table)
// PORTS
//  clk        in   1               system clock, rising edge
//  rst        in   1               synchronous reset, active low
//  cpu_addr   in   ADDR_W          access address, sampled when cpu_req=1 in IDLE
//  cpu_req    in   1               access request, held until cpu_ready
//  cpu_we     in   1               1=write, 0=read
//  cpu_wdata  in   DATA_W          write data
//  cpu_rdata  out  DATA_W          read data, valid in the cycle cpu_ready=1
//  cpu_ready  out  1               single-cycle completion pulse
//  cpu_err    out  1               with cpu_ready: access was unmapped or write-protected
//  dev_sel    out  NUM_REGIONS     one-hot region select, held through the access
//  dev_addr   out  ADDR_W          region-relative offset (addr & MASK_i)
//  dev_we     out  1               single-cycle write strobe to the selected region
//  dev_wdata  out  DATA_W          registered write data
//  dev_rdata  in   NUM_REGIONS*DATA_W  packed per-region read data
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; cpu_ready, cpu_err, dev_we, dev_sel = 0;
//   cpu_rdata, dev_addr, dev_wdata = 0; err_cnt=0; err_addr=0.
//  Decode priority: STATUS_ADDR first, then the lowest region index whose mask matches.
//   Overlapping regions therefore resolve to the lower index.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: on cpu_req, latch addr/we/wdata/region and load lat_cnt = REGION_LAT_i.
//   ACCESS, write: dev_we=1 for exactly 1 cycle, then DONE. Total latency: req to ready = 2 cycles.
//   ACCESS, read: dev_sel held while lat_cnt counts down to 1; dev_rdata[i] is captured at that
//    edge, then DONE. Latency = 1 + REGION_LAT_i cycles.
//   DONE: cpu_ready=1 for 1 cycle, then IDLE. A request that is still held is taken as a new
//    access only on the cycle after ready, so there is no double issue.
//  Error paths (no dev_sel, no dev_we): ACCESS lasts 1 cycle, then DONE with cpu_err=1.
//   On a read, cpu_rdata=0. err_addr <= addr; err_cnt += 1, saturating at 8'hFF.
//   Unmapped: no region hit. Protected: cpu_we=1 to a region with WP bit set.
//  Status register: read returns {err_cnt[7:0], 8'h00} (upper byte) at 1-cycle latency.
//   Bits of err_addr are not readable here; it is exposed on STATUS_ADDR+0 only when
//   cpu_addr[0] is ignored, so err_addr is an internal debug register.
//   Write (any data) clears err_cnt to 0. Status accesses never raise cpu_err.
//  cpu_req dropping mid-access: the access still completes; the ready pulse is still issued.
//  Reset mid-access: abort immediately, with no dev_we and no ready pulse.
//  All outputs are registered; there is no combinational path from cpu_* to dev_*.
// TESTING
//  Read region 0 (LAT=1, dev_rdata0=16'hA5A5) -> dev_sel=8'h01, cpu_ready at cycle 2, rdata=A5A5.
//  Read region with LAT=3 -> ready exactly 4 cycles after req; dev_sel held 3 cycles.
//  Write 16'h1234 to region with WP=1 -> no dev_we, cpu_err=1, err_cnt 0->1.
//  300 unmapped reads -> err_cnt saturates at 8'hFF; status read returns 16'hFF00;
//   a status write returns the next status read to 16'h0000.
//  Overlapping bases (regions 2 and 5 both hit) -> dev_sel=8'h04 only.
//  Assert rst=0 during a LAT=3 read -> next cycle IDLE, all outputs 0, no ready pulse.

Source files
------------

// File: rtl/mmio_region_bus.sv
// mmio_region_bus: base/mask-decoded CPU-to-device bus with per-region read latency,
// write protection and trapping of unmapped/protected accesses into a status register.
module mmio_region_bus #(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h7000, 16'h6000, 16'h5000, 16'h4000,
                                                            16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {NUM_REGIONS{16'h0FFF}},
    parameter logic [NUM_REGIONS*2-1:0] REGION_LAT = {NUM_REGIONS{2'd1}},
    parameter logic [NUM_REGIONS-1:0] REGION_WP = '0,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 16'h48FF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          cpu_ready,
    output logic                          cpu_err,
    output logic [NUM_REGIONS-1:0]        dev_sel,
    output logic [ADDR_W-1:0]             dev_addr,
    output logic                          dev_we,
    output logic [DATA_W-1:0]             dev_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic [1:0] lat_cnt;
    logic we_q, bad_q, stat_q;
    logic [ADDR_W-1:0] addr_q, err_addr;
    logic [7:0] err_cnt;
    logic hit, hit_wp, is_stat, bad, good;
    logic [1:0] hit_lat;
    logic [ADDR_W-1:0] hit_mask;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [DATA_W-1:0] sel_rdata, status_word;
    // Descending scan so the lowest matching index wins on overlap.
    always_comb begin
        hit = 1'b0;
        hit_wp = 1'b0;
        hit_lat = 2'd1;
        hit_mask = '0;
        hit_sel = '0;
        sel_rdata = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((cpu_addr & ~REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                hit_wp = REGION_WP[i];
                hit_lat = REGION_LAT[i*2 +: 2];
                hit_mask = REGION_MASK[i*ADDR_W +: ADDR_W];
                hit_sel = '0;
                hit_sel[i] = 1'b1;
            end
            sel_rdata = sel_rdata | (dev_sel[i] ? dev_rdata[i*DATA_W +: DATA_W] : '0);
        end
    end
    assign is_stat = cpu_addr == STATUS_ADDR;
    assign bad = !is_stat && (!hit || (cpu_we && hit_wp));
    assign good = !is_stat && !bad;
    assign status_word = DATA_W'({err_cnt, 8'h00});
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            lat_cnt <= '0;
            we_q <= 1'b0;
            bad_q <= 1'b0;
            stat_q <= 1'b0;
            addr_q <= '0;
            err_addr <= '0;
            err_cnt <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err <= 1'b0;
            dev_sel <= '0;
            dev_addr <= '0;
            dev_we <= 1'b0;
            dev_wdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err <= 1'b0;
            dev_we <= 1'b0;
            case (state)
                IDLE: if (cpu_req) begin
                    state <= ACCESS;
                    we_q <= cpu_we;
                    bad_q <= bad;
                    stat_q <= is_stat;
                    addr_q <= cpu_addr;
                    lat_cnt <= hit_lat == 2'd0 ? 2'd1 : hit_lat;
                    dev_sel <= good ? hit_sel : '0;
                    dev_addr <= good ? cpu_addr & hit_mask : '0;
                    dev_we <= good && cpu_we;
                    dev_wdata <= cpu_wdata;
                end
                ACCESS: if (we_q || bad_q || stat_q || lat_cnt == 2'd1) begin
                    state <= DONE;
                    cpu_ready <= 1'b1;
                    cpu_err <= bad_q;
                    dev_sel <= '0;
                    cpu_rdata <= stat_q ? status_word : (bad_q || we_q) ? '0 : sel_rdata;
                    if (bad_q) begin
                        err_addr <= addr_q;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else if (stat_q && we_q) begin
                        err_cnt <= '0;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Status accesses never trap, so a recorded fault address can never be the status address.
    always_ff @(posedge clk)
        if (rst) assert (err_cnt == 8'd0 || err_addr != STATUS_ADDR);
endmodule

// File: tb/tb_mmio_region_bus.sv
// tb_mmio_region_bus: directed accesses checked each cycle against a transaction-level timeline model.
module tb_mmio_region_bus;
    localparam logic [127:0] BASE = {16'h7000, 16'h6000, 16'h2000, 16'h4000,
                                     16'h3000, 16'h2000, 16'h1000, 16'h0000};
    localparam logic [127:0] MASK = {16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
                                     16'h00FF, 16'h0FFF, 16'h00FF, 16'h00FF};
    localparam logic [15:0] LAT = {2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
    localparam logic [7:0] WP = 8'b0000_1000;
    localparam logic [15:0] STAT = 16'h48FF;
    logic clk = 1'b0;
    logic rst, cpu_req, cpu_we, cpu_ready, cpu_err, dev_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dev_addr, dev_wdata;
    logic [7:0] dev_sel;
    logic [127:0] dev_rdata;
    int tests = 0, fails = 0, cyc = 0, m_cnt = 0;
    bit mon_en = 0;
    int t_a = -100, t_L = 1;
    logic [7:0] t_sel;
    logic [15:0] t_off, t_wd, t_rd;
    logic t_we, t_weok, t_err;
    int lat_seen;
    logic [7:0] sel_seen;
    logic [15:0] rd_seen, addr_seen;
    logic err_seen;
    mmio_region_bus #(
        .NUM_REGIONS(8), .ADDR_W(16), .DATA_W(16),
        .REGION_BASE(BASE), .REGION_MASK(MASK), .REGION_LAT(LAT), .REGION_WP(WP), .STATUS_ADDR(STAT)
    ) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [15:0] rdv(input int i);
        return i == 0 ? 16'hA5A5 : 16'(16'h1111 * i);
    endfunction
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Expected transaction outcome straight from the decode rules: status, lowest-index hit, WP, latency.
    task automatic predict(input logic [15:0] a, input logic w, input logic [15:0] d);
        int hit;
        int lat;
        t_we = w; t_wd = d; t_sel = '0; t_off = '0; t_weok = 0; t_err = 0; t_rd = '0; t_L = 1;
        if (a == STAT) begin
            t_rd = {8'(m_cnt), 8'h00};
            if (w) m_cnt = 0;
        end else begin
            hit = -1;
            for (int i = 0; i < 8; i++)
                if (hit < 0 && (a & ~MASK[i*16 +: 16]) == BASE[i*16 +: 16]) hit = i;
            if (hit < 0 || (w && WP[hit])) begin
                t_err = 1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                t_sel[hit] = 1'b1;
                t_off = a & MASK[hit*16 +: 16];
                t_weok = w;
                lat = int'(LAT[hit*2 +: 2]);
                t_L = w ? 1 : (lat == 0 ? 1 : lat);
                t_rd = rdv(hit);
            end
        end
    endtask
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d, input bit hold);
        int n;
        bit got;
        predict(a, w, d);
        t_a = cyc + 1;
        cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_req = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (n == 1) begin
                sel_seen = dev_sel;
                addr_seen = dev_addr;
                if (!hold) cpu_req = 1'b0;
            end
            if (cpu_ready) begin
                got = 1;
                rd_seen = cpu_rdata;
                err_seen = cpu_err;
                lat_seen = n;
            end
        end
        cpu_req = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout: no ready for addr %h within 12 cycles", a);
        end
        tick();
    endtask
    // Per-cycle check: outputs as a function of cycles elapsed since the request was accepted.
    always @(negedge clk) if (mon_en) begin
        int k;
        logic [7:0] es;
        logic er, ew;
        k = cyc - t_a;
        es = (k >= 0 && k < t_L) ? t_sel : 8'h00;
        ew = k == 0 && t_weok;
        er = k == t_L;
        chk("cpu_ready", cpu_ready, er);
        chk("cpu_err", cpu_err, er && t_err);
        chk("dev_sel", dev_sel, es);
        chk("dev_we", dev_we, ew);
        if (es != 0) chk("dev_addr", dev_addr, t_off);
        if (ew) chk("dev_wdata", dev_wdata, t_wd);
        if (er && !t_we) chk("cpu_rdata", cpu_rdata, t_rd);
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 8; i++) dev_rdata[i*16 +: 16] = rdv(i);
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        tick();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_sel", dev_sel, 0);
        chk("rst_we", dev_we, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr", dev_addr, 0);
        chk("rst_wdata", dev_wdata, 0);
        rst = 1'b1;
        mon_en = 1;
        tick();
        access(16'h0012, 0, 16'h0, 1);
        chk("r0_sel", sel_seen, 8'h01);
        chk("r0_lat", lat_seen, 2);
        chk("r0_rdata", rd_seen, 16'hA5A5);
        access(16'h7034, 0, 16'h0, 1);
        chk("r7_lat3", lat_seen, 4);
        chk("r7_sel", sel_seen, 8'h80);
        chk("r7_rdata", rd_seen, 16'h7777);
        access(16'h1080, 0, 16'h0, 0);
        chk("drop_req_lat", lat_seen, 3);
        chk("drop_req_rdata", rd_seen, 16'h1111);
        access(16'h60FF, 0, 16'h0, 1);
        chk("lat0_as_1", lat_seen, 2);
        access(16'h40AB, 1, 16'hBEEF, 1);
        chk("wr_lat", lat_seen, 2);
        chk("wr_err", err_seen, 0);
        access(16'h3010, 1, 16'h1234, 1);
        chk("wp_err", err_seen, 1);
        chk("wp_sel", sel_seen, 8'h00);
        access(STAT, 0, 16'h0, 1);
        chk("stat_cnt1", rd_seen, 16'h0100);
        chk("stat_lat", lat_seen, 2);
        access(16'h3010, 0, 16'h0, 1);
        chk("wp_read_ok", rd_seen, 16'h3333);
        access(16'h2010, 0, 16'h0, 1);
        chk("overlap_sel", sel_seen, 8'h04);
        chk("overlap_addr", addr_seen, 16'h0010);
        chk("overlap_lat", lat_seen, 4);
        access(16'h2800, 0, 16'h0, 1);
        chk("r2_only_sel", sel_seen, 8'h04);
        access(16'h9000, 0, 16'h0, 1);
        chk("unmapped_err", err_seen, 1);
        chk("unmapped_rdata", rd_seen, 16'h0000);
        for (int i = 0; i < 300; i++) access(16'hA000 + 16'(i), 0, 16'h0, 1);
        access(STAT, 0, 16'h0, 1);
        chk("stat_sat", rd_seen, 16'hFF00);
        access(STAT, 1, 16'h5A5A, 1);
        chk("stat_wr_noerr", err_seen, 0);
        access(STAT, 0, 16'h0, 1);
        chk("stat_cleared", rd_seen, 16'h0000);
        access(16'h9000, 1, 16'h0, 1);
        access(16'h5000, 0, 16'h0, 1);
        access(STAT, 0, 16'h0, 1);
        chk("stat_cnt2", rd_seen, 16'h0200);
        predict(16'h7034, 0, 16'h0);
        t_a = cyc + 1;
        cpu_addr = 16'h7034; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        chk("abort_pre_sel", dev_sel, 8'h80);
        tick();
        rst = 1'b0;
        cpu_req = 1'b0;
        tick();
        t_a = -100;
        m_cnt = 0;
        rst = 1'b1;
        chk("abort_sel", dev_sel, 8'h00);
        chk("abort_ready", cpu_ready, 0);
        repeat (5) tick();
        access(STAT, 0, 16'h0, 1);
        chk("stat_after_rst", rd_seen, 16'h0000);
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
